code_conv_serial: RTL

CODE_CONV_SERIAL -- requirements
Module: code_conv_serial

---
 rtl/code_conv_pkg.sv | 22 ++
 rtl/code_conv_bit_step.sv | 33 +++
 rtl/code_conv_serial.sv | 125 ++++++++++++
 3 files changed

// File: rtl/code_conv_pkg.sv
// Shared encodings for the serial code converter: conversion modes and FSM states.
package code_conv_pkg;

   typedef enum logic [1:0] {
      BIN2GRAY = 2'd0,
      GRAY2BIN = 2'd1,
      NEGATE   = 2'd2,
      RSVD     = 2'd3
   } code_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Negation ripples its carry upward, so it walks the word LSB first.
   function automatic logic lsb_first(input code_mode_e mode);
      return mode == NEGATE;
   endfunction

endpackage

// File: rtl/code_conv_bit_step.sv
// One bit of a serial code conversion: result bit and updated running accumulator.
module code_conv_bit_step
   import code_conv_pkg::*;
(
   input  code_mode_e mode,
   input  logic       cur,
   input  logic       nbr,
   input  logic       acc,
   output logic       res,
   output logic       acc_next
);

   always_comb begin
      res      = 1'b0;
      acc_next = acc;
      case (mode)
         BIN2GRAY: res = cur ^ nbr;
         GRAY2BIN: begin
            res      = cur ^ acc;
            acc_next = cur ^ acc;
         end
         NEGATE: begin
            res      = ~cur ^ acc;
            acc_next = ~cur & acc;
         end
         default: begin
            res      = 1'b0;
            acc_next = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/code_conv_serial.sv
// Bit-serial Gray/binary/negate converter with valid/ready handshakes on both sides.
module code_conv_serial
   import code_conv_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic             busy
);

   state_e           state;
   code_mode_e       mode_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] res;
   logic [IDX_W-1:0] idx;
   logic             acc;

   logic [WIDTH-1:0] nbr_vec;
   logic [WIDTH-1:0] res_next;
   logic             step_bit;
   logic             acc_next;
   logic             last;
   code_mode_e       req_mode;

   assign req_mode = code_mode_e'(in_mode);

   // Upper neighbour of each bit; the MSB has none, so it sees 0.
   assign nbr_vec = {1'b0, data_q[WIDTH-1:1]};

   assign last = lsb_first(mode_q) ? (idx == IDX_W'(WIDTH - 1)) : (idx == IDX_W'(0));

   code_conv_bit_step u_step (
      .mode     (mode_q),
      .cur      (data_q[idx]),
      .nbr      (nbr_vec[idx]),
      .acc      (acc),
      .res      (step_bit),
      .acc_next (acc_next)
   );

   always_comb begin
      res_next      = res;
      res_next[idx] = step_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mode_q    <= BIN2GRAY;
         data_q    <= '0;
         res       <= '0;
         idx       <= '0;
         acc       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               busy     <= 1'b0;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (req_mode == RSVD) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_data  <= '0;
                     out_err   <= 1'b1;
                  end else begin
                     state  <= PROC;
                     data_q <= in_data;
                     mode_q <= req_mode;
                     res    <= '0;
                     idx    <= lsb_first(req_mode) ? IDX_W'(0) : IDX_W'(WIDTH - 1);
                     acc    <= lsb_first(req_mode);
                  end
               end
            end
            PROC: begin
               res <= res_next;
               acc <= acc_next;
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_data  <= res_next;
                  out_err   <= 1'b0;
               end else if (lsb_first(mode_q)) begin
                  idx <= idx + IDX_W'(1);
               end else begin
                  idx <= idx - IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_data  <= '0;
                  out_err   <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
